// File: rtl/seq_mult_pkg.sv
// ---------------------------------------------------------------------------
// seq_mult_pkg : shared FSM state type and operand-width limits for seq_mult_n
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    function automatic bit width_ok(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_mult_dp.sv
// ---------------------------------------------------------------------------
// seq_mult_dp : magnitude capture, shift-add accumulator and sign fix-up
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_mult_dp #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic                 fix,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   p
);

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] p_reg;
    logic [WIDTH:0]     sum;
    logic               neg;

    // The most negative operand negates to itself, which is its correct unsigned magnitude.
    always_comb begin
        a_mag    = (signed_mode && a[WIDTH-1]) ? -a : a;
        b_mag    = (signed_mode && b[WIDTH-1]) ? -b : b;
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
        acc_next = {sum, acc[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            p_reg  <= '0;
        end else begin
            if (load) begin
                mcand  <= a_mag;
                mplier <= b_mag;
                acc    <= '0;
                neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            end else if (step) begin
                acc    <= acc_next;
                mplier <= mplier >> 1;
            end
            if (fix) begin
                p_reg <= neg ? -acc : acc;
            end
        end
    end

    assign p = p_reg;

endmodule

`default_nettype wire

// File: rtl/seq_mult_n.sv
// ---------------------------------------------------------------------------
// seq_mult_n : WIDTH-generic signed/unsigned shift-add multiplier, valid/ready
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_mult_n
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p
);

    localparam int               CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    generate
        if (!width_ok(WIDTH)) begin : g_width_check
            $error("seq_mult_n: WIDTH must lie in 2..32");
        end
    endgenerate

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             load;
    logic             step;
    logic             fix;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                cnt <= '0;
            end else if (step) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // No early exit: every product takes exactly WIDTH RUN cycles.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        fix       = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == LAST_ITER) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                fix       = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    seq_mult_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .step        (step),
        .fix         (fix),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .p           (p)
    );

endmodule

`default_nettype wire

// File: tb/tb_seq_mult_n.sv
// ---------------------------------------------------------------------------
// tb_seq_mult_n : scoreboard bench for seq_mult_n at WIDTH=4 and WIDTH=8
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seq_mult_n;

    typedef struct {
        logic [15:0] p;
        int          acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid4, in_ready4, sm4, out_valid4, ordy4;
    logic [3:0] a4, b4;
    logic [7:0] p4;
    logic       in_valid8, in_ready8, sm8, out_valid8, ordy8;
    logic [7:0] a8, b8;
    logic [15:0] p8;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t q4[$];
    exp_t q8[$];
    exp_t cur4, cur8;
    bit   chk4 = 1'b0;
    bit   chk8 = 1'b0;
    bit   rnd_bp = 1'b0;

    seq_mult_n #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .signed_mode(sm4), .out_valid(out_valid4),
        .out_ready(ordy4), .p(p4)
    );

    seq_mult_n #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .signed_mode(sm8), .out_valid(out_valid8),
        .out_ready(ordy8), .p(p8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rnd_bp) begin
            #1;
            ordy8 = ($urandom_range(0, 3) != 0);
        end
    end

    // Reference: interpret operands as integers, multiply, wrap to 2*w bits.
    function automatic logic [15:0] ref_mult(input int w, input logic [7:0] av,
                                             input logic [7:0] bv, input bit sm);
        longint x, y, pr, mask;
        mask = (longint'(1) << w) - 1;
        x = longint'(av) & mask;
        y = longint'(bv) & mask;
        if (sm && av[w-1]) x = x - (longint'(1) << w);
        if (sm && bv[w-1]) y = y - (longint'(1) << w);
        pr = x * y;
        return 16'(pr & ((longint'(1) << (2 * w)) - 1));
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid4 === 1'b1) begin
            if (!chk4) begin
                if (q4.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL w4_unexpected: got product %h, expected none", p4);
                end else begin
                    cur4 = q4.pop_front();
                    chk4 = 1'b1;
                    check("w4_product", {8'h00, p4}, cur4.p);
                    check("w4_latency", 16'(cyc - cur4.acc), 16'd5);
                end
            end else begin
                check("w4_hold", {8'h00, p4}, cur4.p);
            end
            if (ordy4) chk4 = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (out_valid8 === 1'b1) begin
            if (!chk8) begin
                if (q8.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL w8_unexpected: got product %h, expected none", p8);
                end else begin
                    cur8 = q8.pop_front();
                    chk8 = 1'b1;
                    check("w8_product", p8, cur8.p);
                    check("w8_latency", 16'(cyc - cur8.acc), 16'd9);
                end
            end else begin
                check("w8_hold", p8, cur8.p);
            end
            if (ordy8) chk8 = 1'b0;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic send(input bit w8, input logic [7:0] av, input logic [7:0] bv,
                        input bit sm, output int acc_cyc);
        exp_t e;
        int   waited;
        bit   ok;
        e.p = ref_mult(w8 ? 8 : 4, av, bv, sm);
        acc_cyc = -1;
        if (w8) begin
            a8 = av; b8 = bv; sm8 = sm; in_valid8 = 1'b1;
        end else begin
            a4 = av[3:0]; b4 = bv[3:0]; sm4 = sm; in_valid4 = 1'b1;
        end
        waited = 0;
        ok = 1'b0;
        while (!ok && waited < 200) begin
            @(negedge clk);
            if (w8 ? in_ready8 : in_ready4) ok = 1'b1;
            else waited++;
        end
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        in_valid4 = 1'b0;
        if (ok) begin
            acc_cyc = cyc;
            e.acc = cyc;
            if (w8) q8.push_back(e);
            else    q4.push_back(e);
        end else begin
            n_vec++; n_bad++;
            $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, expected 1");
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q4.size() != 0 || q8.size() != 0 || out_valid4 || out_valid8) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (t >= 2000) begin
            n_bad++;
            $display("FAIL drain_timeout: got %0d/%0d pending, expected 0/0", q4.size(), q8.size());
        end
        @(posedge clk);
        #1;
    endtask

    logic [3:0] da [6] = '{4'd13, 4'd0, 4'd15, 4'b1000, 4'hD, 4'd7};
    logic [3:0] db [6] = '{4'd11, 4'd15, 4'd0, 4'b1000, 4'd5, 4'hF};
    bit         ds [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        int  acc_now, acc_prev, t;
        logic [3:0] ra4, rb4;
        rst = 1'b1;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; sm4 = 1'b0; ordy4 = 1'b1;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; sm8 = 1'b0; ordy8 = 1'b1;
        acc_prev = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready4",  {15'd0, in_ready4},  16'd1);
        check("rst_out_valid4", {15'd0, out_valid4}, 16'd0);
        check("rst_p4",         {8'd0, p4},          16'd0);
        check("rst_in_ready8",  {15'd0, in_ready8},  16'd1);
        check("rst_out_valid8", {15'd0, out_valid8}, 16'd0);
        check("rst_p8",         p8,                  16'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed WIDTH=4, back-to-back with out_ready high: II must be WIDTH+3.
        for (int i = 0; i < 6; i++) begin
            send(1'b0, {4'h0, da[i]}, {4'h0, db[i]}, ds[i], acc_now);
            if (i > 0) check("w4_ii", 16'(acc_now - acc_prev), 16'd7);
            acc_prev = acc_now;
        end
        drain();

        // Reset during RUN cycle 2 discards the product in flight.
        send(1'b0, 8'd9, 8'd9, 1'b0, acc_now);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", {15'd0, in_ready4},  16'd1);
        check("mid_rst_out_valid", {15'd0, out_valid4}, 16'd0);
        check("mid_rst_p",        {8'd0, p4},          16'd0);
        if (q4.size() != 0) void'(q4.pop_back());
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(1'b0, 8'd6, 8'd7, 1'b0, acc_now);
        drain();

        // Backpressure: stall 10 cycles, stray in_valid pulse mid-stall.
        ordy4 = 1'b0;
        send(1'b0, 8'd13, 8'd11, 1'b0, acc_now);
        t = 0;
        while (out_valid4 !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("bp_out_valid_rise", {15'd0, out_valid4}, 16'd1);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            in_valid4 = (k == 4);
            a4 = 4'd1; b4 = 4'd1;
            @(negedge clk);
            check("bp_in_ready",  {15'd0, in_ready4},  16'd0);
            check("bp_out_valid", {15'd0, out_valid4}, 16'd1);
        end
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        ordy4 = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_out_valid", {15'd0, out_valid4}, 16'd0);
        check("bp_release_in_ready",  {15'd0, in_ready4},  16'd1);
        @(posedge clk);
        #1;
        check("bp_no_latched_req", {15'd0, in_ready4}, 16'd1);
        drain();

        // Directed WIDTH=8 corners.
        send(1'b1, 8'd255, 8'd255, 1'b0, acc_now);
        send(1'b1, 8'h80, 8'h7F, 1'b1, acc_now);
        drain();

        // Random WIDTH=8, both modes, random consumer backpressure.
        rnd_bp = 1'b1;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 1000; i++) begin
                send(1'b1, 8'($urandom), 8'($urandom), m[0], acc_now);
            end
        end
        drain();
        rnd_bp = 1'b0;
        @(posedge clk);
        #2;
        ordy8 = 1'b1;

        // Random WIDTH=4, mixed modes.
        for (int i = 0; i < 200; i++) begin
            ra4 = 4'($urandom);
            rb4 = 4'($urandom);
            send(1'b0, {4'h0, ra4}, {4'h0, rb4}, 1'($urandom), acc_now);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_mult_n.md
# seq_mult_n

Parametrised sequential shift-add multiplier, the successor to the fixed 4x4 array multiplier. It is WIDTH-generic and supports both unsigned and two's-complement signed operation. It exchanges operands and results over valid/ready handshakes. Within the multiplier subsystem it sits between the operand source and any result consumer; one product is in flight at a time.

## Interface
- WIDTH, default 4: operand width in bits. Legal range 2..32. Product width is 2*WIDTH.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  block can accept operands. High only in IDLE.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- signed_mode  input  1  0 = unsigned, 1 = two's-complement. Sampled with the operands.
- out_valid  output  1  product available. High only in DONE.
- out_ready  input  1  consumer takes the product.
- p  output  2*WIDTH  product. Held stable while out_valid=1.

## Operation
- States: IDLE, RUN, FIX, DONE. State is a 2-bit encoding.
- IDLE:
  - in_ready=1.
  - On in_valid: capture operands and go to RUN.
  - Capture: mcand = |a| and mplier = |b|, each a WIDTH-bit unsigned magnitude, taken when signed_mode=1, else the raw value. neg = signed_mode & (a[MSB] ^ b[MSB]). acc=0. cnt=0.
- RUN, one iteration per cycle:
  - If mplier[0], add mcand into acc[2*WIDTH-1:WIDTH] with carry.
  - Shift {carry,acc} right by 1. Shift mplier right by 1. Increment cnt.
  - After WIDTH iterations go to FIX.
- FIX:
  - p_reg = neg ? -acc : acc, negation in two's complement at 2*WIDTH bits.
  - Go to DONE.
- DONE:
  - out_valid=1 and p=p_reg.
  - On out_ready: go to IDLE. p keeps its value until the next FIX.
- Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which fits WIDTH unsigned bits. Worst case (-2^(W-1))^2 = 2^(2W-2) fits the signed 2W result. No overflow is possible in either mode.
- Inputs a, b and signed_mode are ignored outside the IDLE accept cycle.
- A zero operand runs the full WIDTH iterations; there is no early exit.
- Reset values: state=IDLE, in_ready=1, out_valid=0, p=0, all internal registers 0.
- Reset mid-operation, in RUN, FIX or DONE: abort immediately and return to IDLE. The pending product is discarded; p reads 0.

## Timing
- Accept at edge E0, when in_valid & in_ready.
- RUN covers edges E1..E_WIDTH. FIX completes at edge E_(WIDTH+1), and out_valid is visible after that edge.
- Latency from accept edge to out_valid is WIDTH+1 cycles.
- Minimum initiation interval is WIDTH+3 cycles: out_ready tied high, back-to-back in_valid.
- in_ready and out_valid are registered state decodes with no combinational path from inputs.
- out_valid stays high indefinitely while out_ready=0. The handshake completes on the edge where out_valid & out_ready. in_ready rises the following cycle.
- in_valid without in_ready has no effect and leaves no latched request.

## Structure
- Package seq_mult_pkg holds:
  - the typedef enum logic [1:0] for states IDLE=0, RUN=1, FIX=2, DONE=3;
  - the constant range checks for WIDTH.
- One sub-module, seq_mult_dp:
  - contains the datapath: magnitude conversion, acc/mcand/mplier registers, the add-shift step and the final negate;
  - its controls (load, step, fix) are driven from the FSM in seq_mult_n.
- The counter is $clog2(WIDTH+1) bits wide.

## Test plan
- WIDTH=4, unsigned, a=13, b=11 -> p=8'h8F, with out_valid exactly 5 cycles after the accept edge.
- WIDTH=4, signed:
  - a=4'b1000, b=4'b1000 (-8*-8) -> p=8'h40.
  - a=-3, b=5 -> p=8'hF1.
  - a=7, b=-1 -> p=8'hF9.
- WIDTH=4, a=0, b=15 and a=15, b=0 -> p=0. Latency is still 5 cycles.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - p is stable and in_ready stays 0 throughout.
  - A mid-stall in_valid pulse is ignored.
  - Release gives one handshake, then in_ready=1.
- Assert rst during RUN cycle 2 -> state IDLE, out_valid=0, p=0 immediately. A following 6*7 yields 42.
- WIDTH=8:
  - unsigned 255*255 -> 16'hFE01;
  - signed -128*127 -> 16'hC080;
  - random 1000 vectors per mode checked against a reference model.
